// File: rtl/mu_alu.sv
// Multi-cycle Q16.16 ALU: add/sub/mul single-cycle, radix-4 restoring divide, iterative-squaring log2.
// Define MU_ALU_SATURATE_EN to clamp ADD/SUB/MUL/DIV range overflows instead of wrapping.
module mu_alu #(
  parameter int unsigned LOG_ITERS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic        valid,
  output logic [31:0] result,
  output logic        ready,
  output logic        overflow
);

`ifdef MU_ALU_SATURATE_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] PH_DIV  = 2'd0;
  localparam logic [1:0] PH_NORM = 2'd1;
  localparam logic [1:0] PH_ITER = 2'd2;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_MUL   = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_LOG2  = 3'd4;
  localparam logic [2:0] OP_IGAIN = 3'd5;

  localparam logic [5:0] LAST_ITER = 6'(LOG_ITERS - 1);

  function automatic logic [31:0] ovf_value(input logic [31:0] wrapped, input logic neg);
    return SAT_EN ? (neg ? 32'h8000_0000 : 32'h7FFF_FFFF) : wrapped;
  endfunction

  function automatic logic [4:0] lead_one(input logic [31:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (v[i]) idx = 5'(i);
    end
    return idx;
  endfunction

  logic [1:0]  state_q, state_d;
  logic [1:0]  phase_q, phase_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] result_q, result_d;
  logic        ovf_q, ovf_d;
  logic        ready_q, ready_d;
  logic [32:0] rem_q, rem_d;
  logic [47:0] dvd_q, dvd_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] log_m_q, log_m_d;
  logic [31:0] log_acc_q, log_acc_d;
  logic [31:0] first_q, first_d;
  logic        second_q, second_d;

  logic [31:0]        sum_w, diff_w;
  logic               add_ovf, sub_ovf;
  logic signed [63:0] prod_w, mul_sh;
  logic               mul_ovf;
  logic [31:0]        a_mag_in, div_mag;
  logic [32:0]        rem_t;
  logic [47:0]        dvd_t;
  logic               div_neg, div_big;
  logic [31:0]        q32;
  logic [31:0]        log_v, log_m_norm, log_m_next;
  logic [4:0]         log_p;
  logic [15:0]        log_int;
  logic [63:0]        sq;
  logic [31:0]        frac_bit, acc_n, ig_diff;

  assign sum_w    = operand_a + operand_b;
  assign diff_w   = operand_a - operand_b;
  assign add_ovf  = (operand_a[31] == operand_b[31]) && (sum_w[31] != operand_a[31]);
  assign sub_ovf  = (operand_a[31] != operand_b[31]) && (diff_w[31] != operand_a[31]);
  assign prod_w   = {{32{operand_a[31]}}, operand_a} * {{32{operand_b[31]}}, operand_b};
  assign mul_sh   = prod_w >>> 16;
  assign mul_ovf  = !((&mul_sh[63:31]) || (~|mul_sh[63:31]));
  assign a_mag_in = operand_a[31] ? -operand_a : operand_a;
  assign div_mag  = b_q[31] ? -b_q : b_q;

  // Two restoring steps per cycle: 48 quotient bits in 24 cycles; quotient shifts into dvd.
  always_comb begin
    rem_t = rem_q;
    dvd_t = dvd_q;
    for (int unsigned k = 0; k < 2; k++) begin
      rem_t = {rem_t[31:0], dvd_t[47]};
      dvd_t = {dvd_t[46:0], 1'b0};
      if (rem_t >= {1'b0, div_mag}) begin
        rem_t    = rem_t - {1'b0, div_mag};
        dvd_t[0] = 1'b1;
      end
    end
  end

  assign div_neg = a_q[31] ^ b_q[31];
  assign div_big = div_neg ? (dvd_t > 48'h0000_8000_0000) : (dvd_t > 48'h0000_7FFF_FFFF);
  assign q32     = div_neg ? -dvd_t[31:0] : dvd_t[31:0];

  // Mantissa held as 1.31 in [1,2); squaring lands in [1,4), a set top bit means renormalise.
  assign log_v      = second_q ? b_q : a_q;
  assign log_p      = lead_one(log_v);
  assign log_m_norm = log_v << (5'd31 - log_p);
  assign log_int    = {11'b0, log_p} - ((op_q == OP_LOG2) ? 16'd16 : 16'd0);
  assign sq         = {32'b0, log_m_q} * {32'b0, log_m_q};
  assign log_m_next = 32'(sq >> (sq[63] ? 32 : 31));
  assign frac_bit   = 32'h0000_8000 >> cnt_q;
  assign acc_n      = log_acc_q | (sq[63] ? frac_bit : 32'h0);
  assign ig_diff    = first_q - acc_n;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    ovf_d     = ovf_q;
    ready_d   = ready_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    cnt_d     = cnt_q;
    log_m_d   = log_m_q;
    log_acc_d = log_acc_q;
    first_d   = first_q;
    second_d  = second_q;
    case (state_q)
      S_BUSY: begin
        case (phase_q)
          PH_DIV: begin
            rem_d = rem_t;
            dvd_d = dvd_t;
            cnt_d = cnt_q - 6'd1;
            if (cnt_q == 6'd1) begin
              state_d = S_DONE;
              ready_d = 1'b1;
              if (b_q == '0) begin
                ovf_d    = 1'b1;
                result_d = a_q[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
              end else if (div_big) begin
                ovf_d    = 1'b1;
                result_d = ovf_value(q32, div_neg);
              end else begin
                ovf_d    = 1'b0;
                result_d = q32;
              end
            end
          end
          PH_NORM: begin
            if (op_q == OP_LOG2 && (a_q[31] || a_q == '0)) begin
              state_d  = S_DONE;
              ready_d  = 1'b1;
              ovf_d    = 1'b1;
              result_d = 32'h8000_0000;
            end else if (op_q == OP_IGAIN && (a_q == '0 || b_q == '0)) begin
              state_d  = S_DONE;
              ready_d  = 1'b1;
              ovf_d    = 1'b1;
              result_d = '0;
            end else begin
              log_m_d   = log_m_norm;
              log_acc_d = {log_int, 16'h0000};
              cnt_d     = '0;
              phase_d   = PH_ITER;
            end
          end
          default: begin
            log_m_d   = log_m_next;
            log_acc_d = acc_n;
            cnt_d     = cnt_q + 6'd1;
            if (cnt_q == LAST_ITER) begin
              if (op_q == OP_LOG2) begin
                state_d  = S_DONE;
                ready_d  = 1'b1;
                ovf_d    = 1'b0;
                result_d = acc_n;
              end else if (!second_q) begin
                first_d  = acc_n;
                second_d = 1'b1;
                phase_d  = PH_NORM;
              end else begin
                state_d  = S_DONE;
                ready_d  = 1'b1;
                ovf_d    = 1'b0;
                result_d = ig_diff;
              end
            end
          end
        endcase
      end
      default: begin
        if (valid) begin
          op_d     = op;
          a_d      = operand_a;
          b_d      = operand_b;
          second_d = 1'b0;
          state_d  = S_DONE;
          ready_d  = 1'b1;
          case (op)
            OP_ADD: begin
              ovf_d    = add_ovf;
              result_d = add_ovf ? ovf_value(sum_w, operand_a[31]) : sum_w;
            end
            OP_SUB: begin
              ovf_d    = sub_ovf;
              result_d = sub_ovf ? ovf_value(diff_w, operand_a[31]) : diff_w;
            end
            OP_MUL: begin
              ovf_d    = mul_ovf;
              result_d = mul_ovf ? ovf_value(mul_sh[31:0], mul_sh[63]) : mul_sh[31:0];
            end
            OP_DIV: begin
              state_d = S_BUSY;
              phase_d = PH_DIV;
              ready_d = 1'b0;
              rem_d   = '0;
              dvd_d   = {a_mag_in, 16'h0000};
              cnt_d   = 6'd24;
            end
            OP_LOG2, OP_IGAIN: begin
              state_d = S_BUSY;
              phase_d = PH_NORM;
              ready_d = 1'b0;
            end
            default: begin
              ovf_d    = 1'b1;
              result_d = '0;
            end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      phase_q   <= PH_DIV;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      ovf_q     <= 1'b0;
      ready_q   <= 1'b0;
      rem_q     <= '0;
      dvd_q     <= '0;
      cnt_q     <= '0;
      log_m_q   <= '0;
      log_acc_q <= '0;
      first_q   <= '0;
      second_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      result_q  <= result_d;
      ovf_q     <= ovf_d;
      ready_q   <= ready_d;
      rem_q     <= rem_d;
      dvd_q     <= dvd_d;
      cnt_q     <= cnt_d;
      log_m_q   <= log_m_d;
      log_acc_q <= log_acc_d;
      first_q   <= first_d;
      second_q  <= second_d;
    end
  end

  assign result   = result_q;
  assign ready    = ready_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_mu_alu.sv
// Bench for mu_alu: directed vector table, hand sequences for busy/reset corners,
// and randomized ops checked against a plain-arithmetic reference model.
module tb_mu_alu;

  localparam int LI = 16;
`ifdef MU_ALU_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [2:0]  op_i;
  logic [31:0] a_i, b_i;
  logic        valid_i;
  logic [31:0] result;
  logic        ready;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  mu_alu #(.LOG_ITERS(LI)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .op(op_i),
    .operand_a(a_i),
    .operand_b(b_i),
    .valid(valid_i),
    .result(result),
    .ready(ready),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ovf;
    int          tol;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp, input int tol);
    longint d;
    d = longint'($signed(act)) - longint'($signed(exp));
    total++;
    if (d > tol || d < -tol) begin
      bad++;
      $display("FAIL %s: got %08h want %08h (tol %0d)", name, act, exp, tol);
    end
  endtask

  task automatic check_le(input string name, input int act, input int limit);
    total++;
    if (act > limit) begin
      bad++;
      $display("FAIL %s: latency %0d exceeds %0d", name, act, limit);
    end
  endtask

  function automatic int lat_limit(input logic [2:0] o);
    case (o)
      3'd3:    return 34;
      3'd4:    return LI + 3;
      3'd5:    return 2 * (LI + 3) + 1;
      default: return 1;
    endcase
  endfunction

  function automatic void fit(input longint s, output logic [31:0] r, output logic v);
    longint t;
    v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    if (v && SAT) t = (s < 0) ? -64'sd2147483648 : 64'sd2147483647;
    else t = s;
    r = t[31:0];
  endfunction

  function automatic longint floor_q16(input real x);
    return longint'($floor(x * 65536.0));
  endfunction

  function automatic real lg2(input real x);
    return $ln(x) / $ln(2.0);
  endfunction

  function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic v, output int tol);
    longint sa, sb, mag, q;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    tol = 0;
    case (o)
      3'd0: fit(sa + sb, r, v);
      3'd1: fit(sa - sb, r, v);
      3'd2: fit((sa * sb) >>> 16, r, v);
      3'd3: begin
        if (b == 32'h0) begin
          v = 1'b1;
          r = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
          mag = ((sa < 0 ? -sa : sa) * 65536) / (sb < 0 ? -sb : sb);
          fit(((sa < 0) != (sb < 0)) ? -mag : mag, r, v);
        end
      end
      3'd4: begin
        if (sa <= 0) begin
          v = 1'b1;
          r = 32'h8000_0000;
        end else begin
          q   = floor_q16(lg2(real'(sa) / 65536.0));
          v   = 1'b0;
          r   = q[31:0];
          tol = 2;
        end
      end
      3'd5: begin
        if (a == 32'h0 || b == 32'h0) begin
          v = 1'b1;
          r = 32'h0;
        end else begin
          q   = floor_q16(lg2(real'(longint'(a))) - lg2(real'(longint'(b))));
          v   = 1'b0;
          r   = q[31:0];
          tol = 3;
        end
      end
      default: begin
        v = 1'b1;
        r = 32'h0;
      end
    endcase
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic v, output int lat);
    @(negedge clk);
    op_i    = o;
    a_i     = a;
    b_i     = b;
    valid_i = 1'b1;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    lat     = 1;
    while (!ready && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    r = result;
    v = overflow;
  endtask

  vec_t        tbl[$];
  logic [31:0] r, er;
  logic        v, ev;
  int          lat, tol;

  initial begin
    rst_n   = 1'b1;
    valid_i = 1'b0;
    op_i    = '0;
    a_i     = '0;
    b_i     = '0;
    #2 rst_n = 1'b0;
    #10;
    check("reset_result", result, 32'h0, 0);
    check("reset_ready", {31'b0, ready}, 32'h0, 0);
    check("reset_ovf", {31'b0, overflow}, 32'h0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    tbl.push_back('{"add_1p1",     3'd0, 32'h0001_0000, 32'h0001_0000, 32'h0002_0000, 1'b0, 0});
    tbl.push_back('{"sub_3m1p5",   3'd1, 32'h0003_0000, 32'h0001_8000, 32'h0001_8000, 1'b0, 0});
    tbl.push_back('{"add_ovf",     3'd0, 32'h7FFF_0000, 32'h0001_0000, SAT ? 32'h7FFF_FFFF : 32'h8000_0000, 1'b1, 0});
    tbl.push_back('{"sub_ovf",     3'd1, 32'h8000_0000, 32'h0000_0001, SAT ? 32'h8000_0000 : 32'h7FFF_FFFF, 1'b1, 0});
    tbl.push_back('{"mul_2x3",     3'd2, 32'h0002_0000, 32'h0003_0000, 32'h0006_0000, 1'b0, 0});
    tbl.push_back('{"mul_neg",     3'd2, 32'hFFFF_8000, 32'h0004_0000, 32'hFFFE_0000, 1'b0, 0});
    tbl.push_back('{"mul_ovf",     3'd2, 32'h7FFF_0000, 32'h0002_0000, SAT ? 32'h7FFF_FFFF : 32'hFFFE_0000, 1'b1, 0});
    tbl.push_back('{"div_6d2",     3'd3, 32'h0006_0000, 32'h0002_0000, 32'h0003_0000, 1'b0, 0});
    tbl.push_back('{"div_zero_p",  3'd3, 32'h0001_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1, 0});
    tbl.push_back('{"div_zero_n",  3'd3, 32'hFFFF_0000, 32'h0000_0000, 32'h8000_0000, 1'b1, 0});
    tbl.push_back('{"div_min",     3'd3, 32'h8000_0000, 32'h0001_0000, 32'h8000_0000, 1'b0, 0});
    tbl.push_back('{"div_ovf",     3'd3, 32'h7FFF_FFFF, 32'h0000_8000, SAT ? 32'h7FFF_FFFF : 32'hFFFF_FFFE, 1'b1, 0});
    tbl.push_back('{"ig_4_1",      3'd5, 32'd4,         32'd1,         32'h0002_0000, 1'b0, 0});
    tbl.push_back('{"ig_1_8",      3'd5, 32'd1,         32'd8,         32'hFFFD_0000, 1'b0, 0});
    tbl.push_back('{"ig_3_1",      3'd5, 32'd3,         32'd1,         32'h0001_95C0, 1'b0, 1});
    tbl.push_back('{"ig_a0",       3'd5, 32'd0,         32'd5,         32'h0000_0000, 1'b1, 0});
    tbl.push_back('{"log2_one",    3'd4, 32'h0001_0000, 32'h1234_5678, 32'h0000_0000, 1'b0, 0});
    tbl.push_back('{"log2_half",   3'd4, 32'h0000_8000, 32'h0,         32'hFFFF_0000, 1'b0, 0});
    tbl.push_back('{"log2_zero",   3'd4, 32'h0000_0000, 32'h0,         32'h8000_0000, 1'b1, 0});
    tbl.push_back('{"log2_neg",    3'd4, 32'hFFFF_0000, 32'h0,         32'h8000_0000, 1'b1, 0});
    tbl.push_back('{"rsv_7",       3'd7, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, 0});
    tbl.push_back('{"rsv_6",       3'd6, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, 0});
    tbl.push_back('{"add_after",   3'd0, 32'hFFFF_0000, 32'h0000_8000, 32'hFFFF_8000, 1'b0, 0});

    foreach (tbl[i]) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, r, v, lat);
      check({tbl[i].name, "_res"}, r, tbl[i].res, tbl[i].tol);
      check({tbl[i].name, "_ovf"}, {31'b0, v}, {31'b0, tbl[i].ovf}, 0);
      check_le({tbl[i].name, "_lat"}, lat, lat_limit(tbl[i].op));
    end

    // A request presented while a divide is running must be dropped.
    @(negedge clk);
    op_i = 3'd3; a_i = 32'h0006_0000; b_i = 32'h0002_0000; valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (3) @(negedge clk);
    op_i = 3'd0; a_i = 32'h0000_0001; b_i = 32'h0000_0001; valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    lat = 0;
    while (!ready && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check_le("busy_ignore_lat", lat, 34);
    check("busy_ignore_res", result, 32'h0003_0000, 0);
    repeat (4) @(negedge clk);
    check("busy_ignore_hold", result, 32'h0003_0000, 0);
    check("busy_ignore_ready", {31'b0, ready}, 32'h1, 0);

    // Reset in the middle of a divide clears everything at once.
    @(negedge clk);
    op_i = 3'd3; a_i = 32'h0004_0000; b_i = 32'h0002_0000; valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_ready", {31'b0, ready}, 32'h0, 0);
    check("midrst_result", result, 32'h0, 0);
    check("midrst_ovf", {31'b0, overflow}, 32'h0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("midrst_no_done", {31'b0, ready}, 32'h0, 0);

    for (int n = 0; n < 300; n++) begin
      logic [2:0]  o;
      logic [31:0] a, b;
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case (o)
        3'd2: begin
          a = 32'($signed(a) >>> $urandom_range(0, 16));
          b = 32'($signed(b) >>> $urandom_range(0, 16));
        end
        3'd3: begin
          b = 32'($signed(b) >>> $urandom_range(0, 31));
          if ($urandom_range(0, 15) == 0) b = 32'h0;
        end
        3'd4: a = a >> $urandom_range(0, 31);
        3'd5: begin
          a = a >> $urandom_range(0, 31);
          b = b >> $urandom_range(0, 31);
        end
        default: ;
      endcase
      model(o, a, b, er, ev, tol);
      run_op(o, a, b, r, v, lat);
      check($sformatf("rand%0d_op%0d_res a=%08h b=%08h", n, o, a, b), r, er, tol);
      check($sformatf("rand%0d_op%0d_ovf", n, o), {31'b0, v}, {31'b0, ev}, 0);
      check_le($sformatf("rand%0d_op%0d_lat", n, o), lat, lat_limit(o));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
